// File: rtl/alu_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_pkg -- shared ALU opcode encodings, legality check, slot state type (rev 1.0)
//------------------------------------------------------------------------------
package alu_pkg;

  localparam int XLEN = 32;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_OR   = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_LUI  = 4'b1111;

  typedef enum logic [0:0] {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic is_legal_op(input logic [3:0] op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_OR, ALU_AND, ALU_XOR, ALU_SLT,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLTU, ALU_LUI: is_legal_op = 1'b1;
      default:                                      is_legal_op = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_arbiter_if -- one requester's request/response channel pair (rev 1.0)
//------------------------------------------------------------------------------
interface alu_arbiter_if #(
  parameter int XLEN = alu_pkg::XLEN
) ();
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] req_a;
  logic [XLEN-1:0] req_b;
  logic [3:0]      req_op;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/alu_rsp_slot.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_rsp_slot -- single-entry response holding register for one requester (rev 1.0)
//------------------------------------------------------------------------------
module alu_rsp_slot #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_i,
  input  logic            rsp_ready_i,
  input  logic            grant_i,
  input  logic            legal_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic            alu_zero_i,
  output logic            eligible_o,
  output logic            rsp_valid_o,
  output logic [XLEN-1:0] rsp_result_o,
  output logic            rsp_zero_o,
  output logic            rsp_err_o
);
  import alu_pkg::*;

  slot_state_e     state_q;
  logic [XLEN-1:0] result_q;
  logic            zero_q;
  logic            err_q;

  // A full slot that drains this cycle can accept a new result at the same edge.
  assign eligible_o   = req_valid_i && ((state_q == SLOT_EMPTY) || rsp_ready_i);
  assign rsp_valid_o  = (state_q == SLOT_FULL);
  assign rsp_result_o = result_q;
  assign rsp_zero_o   = zero_q;
  assign rsp_err_o    = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= SLOT_EMPTY;
      result_q <= '0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else if (grant_i) begin
      state_q  <= SLOT_FULL;
      result_q <= legal_i ? alu_result_i : '0;
      zero_q   <= legal_i && alu_zero_i;
      err_q    <= !legal_i;
    end else if ((state_q == SLOT_FULL) && rsp_ready_i) begin
      state_q  <= SLOT_EMPTY;
    end
  end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// alu_arbiter -- round-robin sharing of one combinational ALU by two requesters (rev 1.0)
//------------------------------------------------------------------------------
module alu_arbiter #(
  parameter int XLEN = alu_pkg::XLEN
) (
  input  logic            clk,
  input  logic            rst,
  alu_arbiter_if.slave    req0_if,
  alu_arbiter_if.slave    req1_if,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            alu_zero
);
  import alu_pkg::*;

  logic            elig0;
  logic            elig1;
  logic            grant0;
  logic            grant1;
  logic            legal;
  logic            last_grant_q;
  logic            last_grant_d;
  logic [XLEN-1:0] sel_a;
  logic [XLEN-1:0] sel_b;
  logic [3:0]      sel_op;

  always_comb begin
    // last_grant_q = 1 means requester 1 won most recently, so 0 wins a tie.
    grant0       = !rst && elig0 && (!elig1 || last_grant_q);
    grant1       = !rst && elig1 && (!elig0 || !last_grant_q);
    sel_a        = grant1 ? req1_if.req_a  : req0_if.req_a;
    sel_b        = grant1 ? req1_if.req_b  : req0_if.req_b;
    sel_op       = grant1 ? req1_if.req_op : req0_if.req_op;
    legal        = (grant0 || grant1) && is_legal_op(sel_op);
    alu_a        = legal ? sel_a  : '0;
    alu_b        = legal ? sel_b  : '0;
    alu_control  = legal ? sel_op : ALU_ADD;
    last_grant_d = grant0 ? 1'b0 : (grant1 ? 1'b1 : last_grant_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

  assign req0_if.req_ready = grant0;
  assign req1_if.req_ready = grant1;

  alu_rsp_slot #(.XLEN(XLEN)) u_slot0 (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req0_if.req_valid),
    .rsp_ready_i  (req0_if.rsp_ready),
    .grant_i      (grant0),
    .legal_i      (legal),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
    .eligible_o   (elig0),
    .rsp_valid_o  (req0_if.rsp_valid),
    .rsp_result_o (req0_if.rsp_result),
    .rsp_zero_o   (req0_if.rsp_zero),
    .rsp_err_o    (req0_if.rsp_err)
  );

  alu_rsp_slot #(.XLEN(XLEN)) u_slot1 (
    .clk          (clk),
    .rst          (rst),
    .req_valid_i  (req1_if.req_valid),
    .rsp_ready_i  (req1_if.rsp_ready),
    .grant_i      (grant1),
    .legal_i      (legal),
    .alu_result_i (alu_result),
    .alu_zero_i   (alu_zero),
    .eligible_o   (elig1),
    .rsp_valid_o  (req1_if.rsp_valid),
    .rsp_result_o (req1_if.rsp_result),
    .rsp_zero_o   (req1_if.rsp_zero),
    .rsp_err_o    (req1_if.rsp_err)
  );

endmodule
`default_nettype wire
